// File: rtl/dma_multi.sv
// Two-channel DMA engine: an OAM page-copy channel and a general src/dst/length channel
// (burst or HBlank-paced blocks) sharing one address port toward the memory arbiter.
module dma_multi #(
    parameter int unsigned OAM_LEN   = 160,
    parameter logic [15:0] OAM_BASE  = 16'hFE00,
    parameter int unsigned START_DLY = 1,
    parameter int unsigned BLK_BYTES = 16,
    parameter int unsigned CNT_W     = 7
) (
    input  logic        clk1,
    input  logic        nreset6,
    input  logic        step_en,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic [2:0]  reg_sel,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    input  logic        hblank,
    output logic        dma_run,
    output logic        oam_busy,
    output logic        cpu_stall,
    output logic        dma_xfer,
    output logic [15:0] dma_src,
    output logic [15:0] dma_dst
);

    localparam int unsigned DW = $clog2(START_DLY + 1);
    localparam int unsigned BW = $clog2(BLK_BYTES);

    localparam logic [7:0]     OAM_LAST = 8'(OAM_LEN - 1);
    localparam logic [DW-1:0]  DLY_INIT = DW'(START_DLY);
    localparam logic [DW-1:0]  DLY_ONE  = DW'(1);
    localparam logic [BW-1:0]  BLK_LAST = BW'(BLK_BYTES - 1);
    localparam logic [BW-1:0]  BLK_ONE  = BW'(1);
    localparam logic [CNT_W:0] REM_ONE  = (CNT_W + 1)'(1);

    localparam logic [2:0] SEL_OAM_PAGE = 3'd0;
    localparam logic [2:0] SEL_SRC_HI   = 3'd1;
    localparam logic [2:0] SEL_SRC_LO   = 3'd2;
    localparam logic [2:0] SEL_DST_HI   = 3'd3;
    localparam logic [2:0] SEL_DST_LO   = 3'd4;
    localparam logic [2:0] SEL_GEN_CTRL = 3'd5;

    typedef enum logic [1:0] {
        OAM_IDLE,
        OAM_DELAY,
        OAM_RUN
    } oam_state_e;

    typedef enum logic [1:0] {
        GEN_IDLE,
        GEN_BURST,
        GEN_HB_WAIT,
        GEN_HB_BLOCK
    } gen_state_e;

    oam_state_e     oam_state_q;
    logic [7:0]     page_q;
    logic [7:0]     idx_q;
    logic [DW-1:0]  dly_q;

    gen_state_e     gen_state_q;
    logic [15:0]    src_q;
    logic [15:0]    dst_q;
    logic [CNT_W:0] rem_q;
    logic [BW-1:0]  bcnt_q;
    logic           hb_q;
    logic           hb_pend_q;
    logic           cancel_q;

    logic wr_oam, wr_src_hi, wr_src_lo, wr_dst_hi, wr_dst_lo, wr_ctrl;
    logic oam_xfer, gen_step, gen_moving, gen_xfer, gen_active;
    logic blk_end, last_blk, reload, cancel_now, hb_rise;
    logic [CNT_W:0]   n_plus1;
    logic [CNT_W-1:0] rem_m1;
    logic [15:0]      dst_vram;

    assign wr_oam    = cpu_wr && (reg_sel == SEL_OAM_PAGE);
    assign wr_src_hi = cpu_wr && (reg_sel == SEL_SRC_HI);
    assign wr_src_lo = cpu_wr && (reg_sel == SEL_SRC_LO);
    assign wr_dst_hi = cpu_wr && (reg_sel == SEL_DST_HI);
    assign wr_dst_lo = cpu_wr && (reg_sel == SEL_DST_LO);
    assign wr_ctrl   = cpu_wr && (reg_sel == SEL_GEN_CTRL);

    assign oam_busy   = (oam_state_q == OAM_RUN);
    assign gen_moving = (gen_state_q == GEN_BURST) || (gen_state_q == GEN_HB_BLOCK);
    assign gen_active = (gen_state_q != GEN_IDLE);

    // NOTE: a restart write to OAM_PAGE wins over a RUN step in the same clk1,
    // so the byte that step would have moved is never put on the port.
    assign oam_xfer = step_en && oam_busy && !wr_oam;
    assign gen_step = step_en && !oam_busy;
    assign gen_xfer = gen_step && gen_moving;

    assign blk_end    = gen_xfer && (bcnt_q == BLK_LAST);
    assign last_blk   = (rem_q == REM_ONE);
    assign reload     = wr_ctrl && d_in[7] && gen_active;
    assign cancel_now = wr_ctrl && !d_in[7];
    assign hb_rise    = hblank && !hb_q;
    assign n_plus1    = {1'b0, d_in[CNT_W-1:0]} + REM_ONE;
    assign rem_m1     = CNT_W'(rem_q - REM_ONE);
    assign dst_vram   = {3'b100, dst_q[12:0]};

    assign dma_xfer  = oam_xfer || gen_xfer;
    assign dma_run   = (oam_state_q != OAM_IDLE) || gen_moving;
    assign cpu_stall = gen_moving;
    assign dma_src   = oam_xfer ? {page_q, idx_q} : (gen_xfer ? src_q : 16'h0000);
    assign dma_dst   = oam_xfer ? (OAM_BASE + {8'h00, idx_q}) : (gen_xfer ? dst_vram : 16'h0000);

    always_ff @(posedge clk1 or negedge nreset6) begin
        if (!nreset6) begin
            oam_state_q <= OAM_IDLE;
            page_q      <= 8'h00;
            idx_q       <= 8'h00;
            dly_q       <= '0;
        end else if (wr_oam) begin
            page_q      <= d_in;
            idx_q       <= 8'h00;
            dly_q       <= DLY_INIT;
            oam_state_q <= OAM_DELAY;
        end else if (step_en) begin
            case (oam_state_q)
                OAM_DELAY: begin
                    if (dly_q == DLY_ONE) oam_state_q <= OAM_RUN;
                    else                  dly_q       <= dly_q - DLY_ONE;
                end
                OAM_RUN: begin
                    idx_q <= idx_q + 8'd1;
                    if (idx_q == OAM_LAST) oam_state_q <= OAM_IDLE;
                end
                default: oam_state_q <= OAM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk1 or negedge nreset6) begin
        if (!nreset6) begin
            gen_state_q <= GEN_IDLE;
            src_q       <= 16'h0000;
            dst_q       <= 16'h0000;
            rem_q       <= '0;
            bcnt_q      <= '0;
            hb_q        <= 1'b0;
            hb_pend_q   <= 1'b0;
            cancel_q    <= 1'b0;
        end else begin
            hb_q <= hblank;

            if (gen_xfer) begin
                src_q  <= src_q + 16'd1;
                dst_q  <= dst_q + 16'd1;
                bcnt_q <= bcnt_q + BLK_ONE;
            end
            // NOTE: register writes come after the increment so the CPU value wins
            // (last non-blocking assignment to a bit takes effect).
            if (wr_src_hi) src_q[15:8] <= d_in;
            if (wr_src_lo) src_q[7:0]  <= {d_in[7:4], 4'h0};
            if (wr_dst_hi) dst_q[15:8] <= {3'b100, d_in[4:0]};
            if (wr_dst_lo) dst_q[7:0]  <= {d_in[7:4], 4'h0};

            if (reload)       rem_q <= n_plus1;
            else if (blk_end) rem_q <= rem_q - REM_ONE;

            case (gen_state_q)
                GEN_IDLE: begin
                    if (wr_ctrl) begin
                        rem_q       <= n_plus1;
                        bcnt_q      <= '0;
                        cancel_q    <= 1'b0;
                        hb_pend_q   <= 1'b0;
                        gen_state_q <= d_in[7] ? GEN_HB_WAIT : GEN_BURST;
                    end
                end
                GEN_BURST: begin
                    if (blk_end && last_blk && !reload) gen_state_q <= GEN_IDLE;
                end
                GEN_HB_WAIT: begin
                    // Edge is remembered so a rise between step_en pulses is not lost.
                    if (hb_rise) hb_pend_q <= 1'b1;
                    if (cancel_now) begin
                        gen_state_q <= GEN_IDLE;
                    end else if (gen_step && (hb_pend_q || hb_rise)) begin
                        hb_pend_q   <= 1'b0;
                        gen_state_q <= GEN_HB_BLOCK;
                    end
                end
                GEN_HB_BLOCK: begin
                    if (cancel_now) cancel_q <= 1'b1;
                    if (blk_end) begin
                        cancel_q    <= 1'b0;
                        gen_state_q <= (cancel_q || cancel_now || (last_blk && !reload))
                                       ? GEN_IDLE : GEN_HB_WAIT;
                    end
                end
                default: gen_state_q <= GEN_IDLE;
            endcase
        end
    end

    always_comb begin
        d_out = 8'h00;
        if (cpu_rd) begin
            case (reg_sel)
                SEL_OAM_PAGE: d_out = page_q;
                SEL_SRC_HI:   d_out = src_q[15:8];
                SEL_SRC_LO:   d_out = src_q[7:0];
                SEL_DST_HI:   d_out = dst_q[15:8];
                SEL_DST_LO:   d_out = dst_q[7:0];
                SEL_GEN_CTRL: begin
                    d_out    = 8'(rem_m1);
                    d_out[7] = !gen_active;
                end
                default:      d_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_multi.sv
// Directed bench for dma_multi: OAM copy/restart, general burst, HBlank blocks,
// cancel, OAM-over-general arbitration and asynchronous reset mid-transfer.
module tb_dma_multi;

    logic        clk1 = 1'b0;
    logic        nreset6 = 1'b0;
    logic        step_en = 1'b0;
    logic        cpu_wr = 1'b0;
    logic        cpu_rd = 1'b0;
    logic [2:0]  reg_sel = 3'd0;
    logic [7:0]  d_in = 8'h00;
    logic        hblank = 1'b0;
    logic [7:0]  d_out;
    logic        dma_run, oam_busy, cpu_stall, dma_xfer;
    logic [15:0] dma_src, dma_dst;

    int n_cmp = 0;
    int n_err = 0;

    bit step_on = 1'b0;
    int phase = 0;
    int xfer_cnt = 0;
    int step_cnt = 0;
    logic [15:0] src_log[$];
    logic [15:0] dst_log[$];
    logic        busy_log[$];
    logic        stall_log[$];
    int          xstep_log[$];

    dma_multi dut (
        .clk1      (clk1),
        .nreset6   (nreset6),
        .step_en   (step_en),
        .cpu_wr    (cpu_wr),
        .cpu_rd    (cpu_rd),
        .reg_sel   (reg_sel),
        .d_in      (d_in),
        .d_out     (d_out),
        .hblank    (hblank),
        .dma_run   (dma_run),
        .oam_busy  (oam_busy),
        .cpu_stall (cpu_stall),
        .dma_xfer  (dma_xfer),
        .dma_src   (dma_src),
        .dma_dst   (dma_dst)
    );

    always #5 clk1 = ~clk1;

    // step_en: one clk1 in four, changed just after the rising edge
    initial begin
        forever begin
            @(posedge clk1);
            #1;
            phase = (phase + 1) % 4;
            step_en = step_on && (phase == 0);
        end
    end

    always @(negedge clk1) begin
        if (step_en) step_cnt++;
        if (dma_xfer) begin
            xfer_cnt++;
            src_log.push_back(dma_src);
            dst_log.push_back(dma_dst);
            busy_log.push_back(oam_busy);
            stall_log.push_back(cpu_stall);
            xstep_log.push_back(step_cnt);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        xfer_cnt = 0;
        src_log.delete();
        dst_log.delete();
        busy_log.delete();
        stall_log.delete();
        xstep_log.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk1);
    endtask

    task automatic cpu_write(input logic [2:0] sel, input logic [7:0] val);
        @(posedge clk1);
        #1;
        reg_sel = sel;
        d_in    = val;
        cpu_wr  = 1'b1;
        @(posedge clk1);
        #1;
        cpu_wr  = 1'b0;
    endtask

    task automatic cpu_read(input logic [2:0] sel, output logic [7:0] val);
        reg_sel = sel;
        cpu_rd  = 1'b1;
        #1;
        val     = d_out;
        cpu_rd  = 1'b0;
    endtask

    task automatic wait_cnt(input int target, input string what);
        int n = 0;
        while (xfer_cnt < target && n < 3000) begin
            @(negedge clk1);
            #1;
            n++;
        end
        if (xfer_cnt < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: xfers %0d, required %0d", what, xfer_cnt, target);
        end
    endtask

    task automatic wait_quiet(input string what);
        int n = 0;
        while ((dma_run || cpu_stall) && n < 3000) begin
            @(negedge clk1);
            n++;
        end
        if (dma_run || cpu_stall) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: run=%0b stall=%0b, required 0/0", what, dma_run, cpu_stall);
        end
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        nreset6 = 1'b0;
        step_on = 1'b1;
        idle(3);
        n_cmp++;
        if ({dma_run, oam_busy, cpu_stall, dma_xfer, dma_src, dma_dst} !== 36'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {dma_run, oam_busy, cpu_stall, dma_xfer, dma_src, dma_dst});
        end
        nreset6 = 1'b1;
        idle(2);
        cpu_read(3'd5, rd);
        n_cmp++;
        if (rd !== 8'hFF) begin n_err++; $display("FAIL reset_ctrl: got %h, required ff", rd); end
        cpu_read(3'd0, rd);
        n_cmp++;
        if (rd !== 8'h00) begin n_err++; $display("FAIL reset_page: got %h, required 00", rd); end
        cpu_read(3'd2, rd);
        n_cmp++;
        if (rd !== 8'h00) begin n_err++; $display("FAIL reset_src_lo: got %h, required 00", rd); end
        reg_sel = 3'd5;
        #1;
        n_cmp++;
        if (d_out !== 8'h00) begin n_err++; $display("FAIL dout_no_rd: got %h, required 00", d_out); end
    endtask

    task automatic test_oam();
        int s0;
        int bad;
        clear_log();
        cpu_write(3'd0, 8'hC1);
        s0 = step_cnt;
        @(negedge clk1);
        n_cmp++;
        if ({dma_run, oam_busy} !== 2'b10) begin
            n_err++;
            $display("FAIL oam_delay_flags: run/busy %b, required 10", {dma_run, oam_busy});
        end
        wait_cnt(160, "oam_copy");
        @(negedge clk1);
        n_cmp++;
        if (dma_run !== 1'b0) begin n_err++; $display("FAIL oam_run_drop: got %b, required 0", dma_run); end
        idle(8);
        n_cmp++;
        if (xfer_cnt !== 160) begin n_err++; $display("FAIL oam_count: got %0d, required 160", xfer_cnt); end
        n_cmp++;
        if (xstep_log.size() == 0 || xstep_log[0] !== s0 + 2) begin
            n_err++;
            $display("FAIL oam_start_delay: first xfer step %0d, required %0d",
                     xstep_log.size() ? xstep_log[0] : -1, s0 + 2);
        end
        bad = 0;
        for (int i = 0; i < src_log.size() && i < 160; i++) begin
            if (src_log[i] !== 16'hC100 + 16'(i) || dst_log[i] !== 16'hFE00 + 16'(i) || busy_log[i] !== 1'b1)
                bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL oam_addr_seq: %0d bad entries, required 0", bad); end
    endtask

    task automatic test_oam_restart();
        logic [7:0] rd;
        logic [15:0] exp_src[6];
        logic [15:0] got[6];
        clear_log();
        cpu_write(3'd0, 8'hC1);
        wait_cnt(50, "oam_first50");
        cpu_write(3'd0, 8'hD0);
        wait_cnt(210, "oam_restart");
        idle(8);
        n_cmp++;
        if (xfer_cnt !== 210) begin n_err++; $display("FAIL restart_count: got %0d, required 210", xfer_cnt); end
        exp_src = '{16'hC131, 16'hFE31, 16'hD000, 16'hFE00, 16'hD09F, 16'hFE9F};
        got[0] = src_log.size() > 49  ? src_log[49]  : 16'hxxxx;
        got[1] = dst_log.size() > 49  ? dst_log[49]  : 16'hxxxx;
        got[2] = src_log.size() > 50  ? src_log[50]  : 16'hxxxx;
        got[3] = dst_log.size() > 50  ? dst_log[50]  : 16'hxxxx;
        got[4] = src_log.size() > 209 ? src_log[209] : 16'hxxxx;
        got[5] = dst_log.size() > 209 ? dst_log[209] : 16'hxxxx;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (got[i] !== exp_src[i]) begin
                n_err++;
                $display("FAIL restart_addr[%0d]: got %h, required %h", i, got[i], exp_src[i]);
            end
        end
        cpu_read(3'd0, rd);
        n_cmp++;
        if (rd !== 8'hD0) begin n_err++; $display("FAIL restart_page_rd: got %h, required d0", rd); end
    endtask

    task automatic test_burst();
        logic [7:0] rd;
        logic [7:0] exp_rd[4];
        logic [2:0] rd_sel[4];
        int bad;
        clear_log();
        cpu_write(3'd1, 8'h41);
        cpu_write(3'd2, 8'h23);
        cpu_write(3'd3, 8'h9F);
        cpu_write(3'd4, 8'hF5);
        cpu_write(3'd5, 8'h01);
        wait_cnt(32, "burst");
        wait_quiet("burst_end");
        idle(8);
        n_cmp++;
        if (xfer_cnt !== 32) begin n_err++; $display("FAIL burst_count: got %0d, required 32", xfer_cnt); end
        bad = 0;
        for (int i = 0; i < src_log.size() && i < 32; i++) begin
            if (src_log[i] !== 16'h4120 + 16'(i)) bad++;
            if (dst_log[i] !== ((i < 16) ? 16'h9FF0 + 16'(i) : 16'h8000 + 16'(i - 16))) bad++;
            if (stall_log[i] !== 1'b1 || busy_log[i] !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL burst_seq: %0d bad fields, required 0", bad); end
        rd_sel = '{3'd5, 3'd1, 3'd2, 3'd4};
        exp_rd = '{8'hFF, 8'h41, 8'h40, 8'h10};
        for (int i = 0; i < 4; i++) begin
            cpu_read(rd_sel[i], rd);
            n_cmp++;
            if (rd !== exp_rd[i]) begin
                n_err++;
                $display("FAIL burst_reg%0d: got %h, required %h", rd_sel[i], rd, exp_rd[i]);
            end
        end
    endtask

    task automatic test_hblank();
        logic [7:0] rd;
        logic [7:0] exp_ctrl[3];
        exp_ctrl = '{8'h01, 8'h00, 8'hFF};
        hblank = 1'b1;
        idle(4);
        clear_log();
        cpu_write(3'd5, 8'h82);
        cpu_read(3'd5, rd);
        n_cmp++;
        if (rd !== 8'h02) begin n_err++; $display("FAIL hb_ctrl_start: got %h, required 02", rd); end
        idle(40);
        n_cmp++;
        if (xfer_cnt !== 0) begin n_err++; $display("FAIL hb_level_no_edge: got %0d xfers, required 0", xfer_cnt); end
        for (int b = 1; b <= 3; b++) begin
            hblank = 1'b0;
            idle(3);
            hblank = 1'b1;
            wait_cnt(16 * b, "hb_block");
            wait_quiet("hb_block_end");
            idle(20);
            n_cmp++;
            if (xfer_cnt !== 16 * b) begin
                n_err++;
                $display("FAIL hb_count_blk%0d: got %0d, required %0d", b, xfer_cnt, 16 * b);
            end
            cpu_read(3'd5, rd);
            n_cmp++;
            if (rd !== exp_ctrl[b-1]) begin
                n_err++;
                $display("FAIL hb_ctrl_blk%0d: got %h, required %h", b, rd, exp_ctrl[b-1]);
            end
        end
        n_cmp++;
        if (src_log.size() < 48 || src_log[0] !== 16'h4140 || src_log[47] !== 16'h416F ||
            dst_log[0] !== 16'h8010 || dst_log[47] !== 16'h803F) begin
            n_err++;
            $display("FAIL hb_addr_ends: size %0d, required 48 with src 4140..416f dst 8010..803f",
                     src_log.size());
        end
    endtask

    task automatic test_cancel_arb();
        logic [7:0] rd;
        int bad, g, o, first_oam;
        clear_log();
        cpu_write(3'd5, 8'h82);
        hblank = 1'b0;
        idle(3);
        hblank = 1'b1;
        wait_cnt(16, "cancel_blk");
        wait_quiet("cancel_blk_end");
        cpu_write(3'd5, 8'h00);
        cpu_read(3'd5, rd);
        n_cmp++;
        if (rd !== 8'h81) begin n_err++; $display("FAIL cancel_ctrl: got %h, required 81", rd); end
        hblank = 1'b0;
        idle(3);
        hblank = 1'b1;
        idle(40);
        n_cmp++;
        if (xfer_cnt !== 16) begin n_err++; $display("FAIL cancel_no_more: got %0d, required 16", xfer_cnt); end

        clear_log();
        cpu_write(3'd1, 8'h10);
        cpu_write(3'd2, 8'h00);
        cpu_write(3'd3, 8'h88);
        cpu_write(3'd4, 8'h00);
        cpu_write(3'd5, 8'h01);
        wait_cnt(10, "arb_gen10");
        cpu_write(3'd0, 8'hC1);
        wait_cnt(192, "arb_total");
        wait_quiet("arb_end");
        idle(8);
        n_cmp++;
        if (xfer_cnt !== 192) begin n_err++; $display("FAIL arb_count: got %0d, required 192", xfer_cnt); end
        bad = 0; g = 0; o = 0; first_oam = -1;
        for (int i = 0; i < src_log.size(); i++) begin
            if (busy_log[i] === 1'b1) begin
                if (first_oam < 0) first_oam = i;
                if (src_log[i] !== 16'hC100 + 16'(o) || dst_log[i] !== 16'hFE00 + 16'(o)) bad++;
                o++;
            end else begin
                if (src_log[i] !== 16'h1000 + 16'(g) || dst_log[i] !== 16'h8800 + 16'(g)) bad++;
                g++;
            end
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL arb_seq: %0d bad entries, required 0", bad); end
        n_cmp++;
        if (g !== 32 || o !== 160) begin
            n_err++;
            $display("FAIL arb_split: gen %0d oam %0d, required 32/160", g, o);
        end
        n_cmp++;
        if (first_oam !== 11) begin n_err++; $display("FAIL arb_first_oam: got %0d, required 11", first_oam); end
        n_cmp++;
        if (src_log.size() < 172 || src_log[171] !== 16'h100B) begin
            n_err++;
            $display("FAIL arb_resume: got %h, required 100b", src_log.size() > 171 ? src_log[171] : 16'hxxxx);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd;
        int snap, n;
        clear_log();
        cpu_write(3'd5, 8'h0F);
        wait_cnt(5, "mid_start");
        n = 0;
        while (!dma_xfer && n < 40) begin
            @(posedge clk1);
            #2;
            n++;
        end
        n_cmp++;
        if (dma_xfer !== 1'b1) begin n_err++; $display("FAIL mid_find_xfer: got %b, required 1", dma_xfer); end
        nreset6 = 1'b0;
        #1;
        n_cmp++;
        if ({dma_run, oam_busy, cpu_stall, dma_xfer, dma_src, dma_dst} !== 36'h0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got %h, required 0",
                     {dma_run, oam_busy, cpu_stall, dma_xfer, dma_src, dma_dst});
        end
        snap = xfer_cnt;
        idle(10);
        nreset6 = 1'b1;
        cpu_read(3'd5, rd);
        n_cmp++;
        if (rd !== 8'hFF) begin n_err++; $display("FAIL mid_ctrl: got %h, required ff", rd); end
        cpu_read(3'd1, rd);
        n_cmp++;
        if (rd !== 8'h00) begin n_err++; $display("FAIL mid_src_hi: got %h, required 00", rd); end
        idle(40);
        n_cmp++;
        if (xfer_cnt !== snap || cpu_stall !== 1'b0) begin
            n_err++;
            $display("FAIL mid_no_xfer: xfers %0d stall %b, required %0d 0", xfer_cnt, cpu_stall, snap);
        end
    endtask

    initial begin
        test_reset();
        test_oam();
        test_oam_restart();
        test_burst();
        test_hblank();
        test_cancel_arb();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
